// File: rtl/rmt_act_pkg.sv
// Shared action-stage definitions: sub-action opcodes, field offsets and width.
// Used by the operand crossbar and its per-container operand selectors.
package rmt_act_pkg;

    localparam int ACT_LEN = 25;

    localparam logic [3:0] OP_ADD    = 4'b0001;
    localparam logic [3:0] OP_SUB    = 4'b0010;
    localparam logic [3:0] OP_STORE  = 4'b0011;
    localparam logic [3:0] OP_LOAD0  = 4'b0100;
    localparam logic [3:0] OP_LOAD1  = 4'b0101;
    localparam logic [3:0] OP_LOAD2  = 4'b0110;
    localparam logic [3:0] OP_LOAD3  = 4'b0111;
    localparam logic [3:0] OP_LOAD4  = 4'b1000;
    localparam logic [3:0] OP_ADDI   = 4'b1001;
    localparam logic [3:0] OP_SUBI   = 4'b1010;
    localparam logic [3:0] OP_LOAD5  = 4'b1011;
    localparam logic [3:0] OP_SET    = 4'b1110;

    localparam int OP_HI   = 24;
    localparam int OP_LO   = 21;
    localparam int STA_HI  = 20;
    localparam int STA_LO  = 16;
    localparam int IDXA_HI = 18;
    localparam int IDXA_LO = 16;
    localparam int IDXB_HI = 13;
    localparam int IDXB_LO = 11;
    localparam int IMM_HI  = 15;
    localparam int IMM_LO  = 0;

endpackage

// File: rtl/crossbar_pipe_if.sv
// PHV/action input bundle and ALU operand output bundle of the operand crossbar.
// slave is the crossbar's view, master the producer/consumer side.
interface crossbar_pipe_if #(
    parameter int N6       = 8,
    parameter int N4       = 8,
    parameter int N2       = 8,
    parameter int W6       = 48,
    parameter int W4       = 32,
    parameter int W2       = 16,
    parameter int META_LEN = 256,
    parameter int ACT_LEN  = rmt_act_pkg::ACT_LEN,
    parameter int ERR_W    = 16
) ();
    localparam int NUM_ACT = N6 + N4 + N2 + 1;
    localparam int PHV_LEN = N6*W6 + N4*W4 + N2*W2 + META_LEN;

    logic [PHV_LEN-1:0]         phv_in;
    logic                       phv_in_valid;
    logic [ACT_LEN*NUM_ACT-1:0] action_in;
    logic                       action_in_valid;
    logic                       ready_out;
    logic [N6*W6-1:0]           alu_in_6B_1;
    logic [N6*W6-1:0]           alu_in_6B_2;
    logic [N4*W4-1:0]           alu_in_4B_1;
    logic [N4*W4-1:0]           alu_in_4B_2;
    logic [N4*W4-1:0]           alu_in_4B_3;
    logic [N2*W2-1:0]           alu_in_2B_1;
    logic [N2*W2-1:0]           alu_in_2B_2;
    logic [META_LEN-1:0]        phv_remain_data;
    logic [ACT_LEN*NUM_ACT-1:0] action_out;
    logic                       alu_in_valid;
    logic                       ready_in;
    logic [ERR_W-1:0]           idx_err_cnt;

    modport slave (
        input  phv_in, phv_in_valid, action_in, action_in_valid, ready_in,
        output ready_out, alu_in_6B_1, alu_in_6B_2, alu_in_4B_1, alu_in_4B_2,
               alu_in_4B_3, alu_in_2B_1, alu_in_2B_2, phv_remain_data,
               action_out, alu_in_valid, idx_err_cnt
    );

    modport master (
        output phv_in, phv_in_valid, action_in, action_in_valid, ready_in,
        input  ready_out, alu_in_6B_1, alu_in_6B_2, alu_in_4B_1, alu_in_4B_2,
               alu_in_4B_3, alu_in_2B_1, alu_in_2B_2, phv_remain_data,
               action_out, alu_in_valid, idx_err_cnt
    );
endinterface

// File: rtl/operand_sel.sv
// Decodes one sub-action into the A/B operands of a single container.
// err_o counts how many operand indices point past the end of the class.
module operand_sel
    import rmt_act_pkg::*;
#(
    parameter int W     = 48,
    parameter int N     = 8,
    parameter int SELF  = 0,
    parameter bit IS_4B = 1'b0
) (
    input  logic [N*W-1:0]     cont_i,
    input  logic [ACT_LEN-1:0] act_i,
    output logic [W-1:0]       a_o,
    output logic [W-1:0]       b_o,
    output logic [1:0]         err_o
);
    logic [3:0]  op;
    logic [2:0]  idx_a;
    logic [2:0]  idx_b;
    logic [15:0] imm;
    logic [4:0]  sta;
    logic [W-1:0] sel_a;
    logic [W-1:0] sel_b;
    logic [W-1:0] imm_w;
    logic [W-1:0] sta_w;
    logic        err_a;
    logic        err_b;
    logic        unused_sta;

    assign op    = act_i[OP_HI:OP_LO];
    assign idx_a = act_i[IDXA_HI:IDXA_LO];
    assign idx_b = act_i[IDXB_HI:IDXB_LO];
    assign imm   = act_i[IMM_HI:IMM_LO];
    assign sta   = act_i[STA_HI:STA_LO];
    assign imm_w = W'(imm);
    assign sta_w = W'(sta);
    assign err_a = (int'(idx_a) >= N);
    assign err_b = (int'(idx_b) >= N);
    // storeA is only consumed by the 4B class
    assign unused_sta = ^sta;

    // An out-of-range index never matches, so the operand falls back to zero.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < N; k++) begin
            if (idx_a == 3'(k)) sel_a = cont_i[k*W +: W];
            if (idx_b == 3'(k)) sel_b = cont_i[k*W +: W];
        end
    end

    always_comb begin
        a_o   = cont_i[SELF*W +: W];
        b_o   = '0;
        err_o = 2'd0;
        case (op)
            OP_ADD, OP_SUB: begin
                a_o   = sel_a;
                b_o   = sel_b;
                err_o = {1'b0, err_a} + {1'b0, err_b};
            end
            OP_ADDI, OP_SUBI: begin
                a_o   = sel_a;
                b_o   = imm_w;
                err_o = {1'b0, err_a};
            end
            OP_SET: begin
                a_o = '0;
                b_o = imm_w;
            end
            OP_STORE: begin
                if (IS_4B) begin
                    a_o = sta_w;
                    b_o = imm_w;
                end
            end
            OP_LOAD0, OP_LOAD1, OP_LOAD2, OP_LOAD3, OP_LOAD4, OP_LOAD5: begin
                if (IS_4B) begin
                    a_o   = sel_a;
                    b_o   = sel_b;
                    err_o = {1'b0, err_a} + {1'b0, err_b};
                end
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/crossbar_pipe.sv
// Operand crossbar for one action stage: joins PHV and action beats, decodes
// per-container operands, and presents them through a 2-entry skid buffer.
module crossbar_pipe #(
    parameter int STAGE_ID = 0,
    parameter int N6       = 8,
    parameter int N4       = 8,
    parameter int N2       = 8,
    parameter int W6       = 48,
    parameter int W4       = 32,
    parameter int W2       = 16,
    parameter int META_LEN = 256,
    parameter int ACT_LEN  = rmt_act_pkg::ACT_LEN,
    parameter int ERR_W    = 16
) (
    input logic            clk,
    input logic            rst_n,
    crossbar_pipe_if.slave bus
);
    localparam int NUM_ACT = N6 + N4 + N2 + 1;
    localparam int PHV_LEN = N6*W6 + N4*W4 + N2*W2 + META_LEN;

    // Empty block marks an unsupported configuration in the elaborated hierarchy
    if (STAGE_ID < 0 || N6 < 1 || N6 > 8 || N4 < 1 || N4 > 8 || N2 < 1 || N2 > 8) begin : g_cfg_invalid
    end

    typedef struct packed {
        logic [N6*W6-1:0]           a6;
        logic [N6*W6-1:0]           b6;
        logic [N4*W4-1:0]           a4;
        logic [N4*W4-1:0]           b4;
        logic [N4*W4-1:0]           c4;
        logic [N2*W2-1:0]           a2;
        logic [N2*W2-1:0]           b2;
        logic [META_LEN-1:0]        meta;
        logic [ACT_LEN*NUM_ACT-1:0] act;
    } beat_t;

    logic [N6*W6-1:0] cont6, a6, b6;
    logic [N4*W4-1:0] cont4, a4, b4;
    logic [N2*W2-1:0] cont2, a2, b2;
    logic [1:0]       err6 [N6];
    logic [1:0]       err4 [N4];
    logic [1:0]       err2 [N2];
    logic [7:0]       err_sum;
    logic [ERR_W:0]   err_tot;

    beat_t            beat_new, head_q, head_d, tail_q, tail_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             push, pop;

    assign cont6 = bus.phv_in[PHV_LEN-1 -: N6*W6];
    assign cont4 = bus.phv_in[META_LEN + N2*W2 +: N4*W4];
    assign cont2 = bus.phv_in[META_LEN +: N2*W2];

    genvar gi;
    for (gi = 0; gi < N6; gi++) begin : g_sel6
        operand_sel #(.W(W6), .N(N6), .SELF(gi), .IS_4B(1'b0)) u_sel (
            .cont_i(cont6), .act_i(bus.action_in[(1+N2+N4+gi)*ACT_LEN +: ACT_LEN]),
            .a_o(a6[gi*W6 +: W6]), .b_o(b6[gi*W6 +: W6]), .err_o(err6[gi]));
    end
    for (gi = 0; gi < N4; gi++) begin : g_sel4
        operand_sel #(.W(W4), .N(N4), .SELF(gi), .IS_4B(1'b1)) u_sel (
            .cont_i(cont4), .act_i(bus.action_in[(1+N2+gi)*ACT_LEN +: ACT_LEN]),
            .a_o(a4[gi*W4 +: W4]), .b_o(b4[gi*W4 +: W4]), .err_o(err4[gi]));
    end
    for (gi = 0; gi < N2; gi++) begin : g_sel2
        operand_sel #(.W(W2), .N(N2), .SELF(gi), .IS_4B(1'b0)) u_sel (
            .cont_i(cont2), .act_i(bus.action_in[(1+gi)*ACT_LEN +: ACT_LEN]),
            .a_o(a2[gi*W2 +: W2]), .b_o(b2[gi*W2 +: W2]), .err_o(err2[gi]));
    end

    always_comb begin
        err_sum = 8'd0;
        for (int k = 0; k < N6; k++) err_sum = err_sum + 8'(err6[k]);
        for (int k = 0; k < N4; k++) err_sum = err_sum + 8'(err4[k]);
        for (int k = 0; k < N2; k++) err_sum = err_sum + 8'(err2[k]);
    end

    always_comb begin
        beat_new.a6   = a6;
        beat_new.b6   = b6;
        beat_new.a4   = a4;
        beat_new.b4   = b4;
        beat_new.c4   = cont4;
        beat_new.a2   = a2;
        beat_new.b2   = b2;
        beat_new.meta = bus.phv_in[META_LEN-1:0];
        beat_new.act  = bus.action_in;
    end

    // ready_q reflects occupancy, so a push never lands on a full buffer.
    assign push    = bus.phv_in_valid & bus.action_in_valid & ready_q;
    assign pop     = (cnt_q != 2'd0) & bus.ready_in;
    assign err_tot = {1'b0, err_cnt_q} + (ERR_W+1)'(err_sum);

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        cnt_d     = cnt_q;
        err_cnt_d = err_cnt_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = beat_new;
                else               tail_d = beat_new;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: head_d = beat_new;
            default: ;
        endcase
        ready_d = (cnt_d <= 2'd1);
        if (push) err_cnt_d = err_tot[ERR_W] ? '1 : err_tot[ERR_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= 2'd0;
            ready_q   <= 1'b1;
            err_cnt_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.ready_out       = ready_q;
    assign bus.alu_in_valid    = (cnt_q != 2'd0);
    assign bus.alu_in_6B_1     = head_q.a6;
    assign bus.alu_in_6B_2     = head_q.b6;
    assign bus.alu_in_4B_1     = head_q.a4;
    assign bus.alu_in_4B_2     = head_q.b4;
    assign bus.alu_in_4B_3     = head_q.c4;
    assign bus.alu_in_2B_1     = head_q.a2;
    assign bus.alu_in_2B_2     = head_q.b2;
    assign bus.phv_remain_data = head_q.meta;
    assign bus.action_out      = head_q.act;
    assign bus.idx_err_cnt     = err_cnt_q;
endmodule

// File: doc/crossbar_pipe.md
Name: crossbar_pipe

Overview:
- Parametrised operand crossbar for one RMT action stage. It joins a PHV beat with its action beat and decodes each per-container sub-action.
- It routes PHV containers or immediates onto the ALU operand buses.
- Sits between key/lookup output and the ALU array of each stage.
- Successor to the fixed 8/8/8 crossbar, adding:
  - configurable container counts,
  - a true valid/ready join,
  - a 2-entry skid buffer with registered ready,
  - action/operand alignment inside the block,
  - an out-of-range-index error counter.

Parameters:
- STAGE_ID, 0, stage index; informational only.
- N6, 8, number of 6B containers (1..8).
- N4, 8, number of 4B containers (1..8).
- N2, 8, number of 2B containers (1..8).
- W6 / W4 / W2, 48 / 32 / 16, container widths.
- META_LEN, 256, metadata/conditional tail of PHV; passed through.
- ACT_LEN, 25, bits per sub-action.
- NUM_ACT, N6+N4+N2+1, sub-actions per action beat (derived).
- PHV_LEN, N6*W6+N4*W4+N2*W2+META_LEN, derived.
- ERR_W, 16, error counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- phv_in  in  PHV_LEN  containers MSB-first: 6B[N6-1]..6B[0], 4B[N4-1]..4B[0], 2B[N2-1]..2B[0], then metadata
- phv_in_valid  in  1  PHV beat valid
- action_in  in  ACT_LEN*NUM_ACT  sub-actions; slot k at bits [(k+1)*ACT_LEN-1 -: ACT_LEN]
- action_in_valid  in  1  action beat valid
- ready_out  out  1  accept; applies to both inputs jointly
- alu_in_6B_1, alu_in_6B_2  out  N6*W6  6B operands A/B; container i at [(i+1)*W6-1 -: W6]
- alu_in_4B_1, alu_in_4B_2, alu_in_4B_3  out  N4*W4  4B operands A/B and original container value
- alu_in_2B_1, alu_in_2B_2  out  N2*W2  2B operands A/B
- phv_remain_data  out  META_LEN  phv_in[META_LEN-1:0]
- action_out  out  ACT_LEN*NUM_ACT  action beat aligned with the operands
- alu_in_valid  out  1  output beat valid
- ready_in  in  1  downstream ready
- idx_err_cnt  out  ERR_W  count of out-of-range source indices, saturating

Behaviour:
- Sub-action slot map:
  - slot 0 is unused (conditional).
  - 2B container i uses slot 1+i.
  - 4B container i uses slot 1+N2+i.
  - 6B container i uses slot 1+N2+N4+i.
- Sub-action fields: op=[24:21], idxA=[18:16], idxB=[13:11], imm=[15:0], storeA=[20:16].
- Decode, all classes:
  - 0001, 0010: A=cont[idxA], B=cont[idxB].
  - 1001, 1010: A=cont[idxA], B=zero-extended imm (truncated to W2 for 2B).
  - 1110: A=0, B=imm.
  - default: A=cont[i], B=0.
- Decode, 4B only, additional ops:
  - 0100, 0101, 0110, 0111, 1000, 1011: A=cont[idxA], B=cont[idxB].
  - 0011 (store): A=zero-extended storeA, B=zero-extended imm.
  - alu_in_4B_3[i] is always cont4[i].
- An index ≥ N of its class selects 0 for that operand.
  - Each offending operand-select increments idx_err_cnt by 1 per accepted beat.
  - Multiple errors in one beat add their count; the counter saturates at all-ones.
- Join: a transfer occurs when phv_in_valid && action_in_valid && ready_out.
  - If only one input is valid, nothing is consumed.
  - Producers must hold their inputs stable until the transfer.
- Pipeline: decode result, phv_remain_data and action_out are registered together. Latency is 1 cycle from transfer to alu_in_valid.
- Output stage is a 2-entry skid buffer:
  - ready_out is a register, =1 while at most 1 entry is occupied.
  - Output beat is held stable while alu_in_valid && !ready_in.
  - Beats leave in order; there is no loss or duplication.
  - Simultaneous push and pop keeps occupancy constant.
  - Full (2 entries): ready_out=0 the cycle after the second push.
- Reset, asynchronous, any time, including mid-beat: all outputs 0 except ready_out=1; skid buffer emptied; idx_err_cnt=0. In-flight beats are dropped.
- No combinational path from ready_in to ready_out or from any input to any output.

Decomposition:
- Shared package rmt_act_pkg holds:
  - opcode localparams (OP_ADD=0001, OP_SUB=0010, OP_STORE=0011, OP_ADDI=1001, OP_SUBI=1010, OP_SET=1110, load family);
  - sub-action field offsets;
  - ACT_LEN.
- One sub-module, operand_sel, instantiated per container class. Parameters W, N, IS_4B. It takes the container vector plus one sub-action and produces A/B plus an error flag (combinational).
- The top level holds the join, pipeline register, skid buffer and counter.

Test Plan:
- Default params; 6B[3]=0x0000_1111_2222, 6B[5]=0x5; 6B slot 3 op=0001, idxA=3, idxB=5; ready_in=1 -> one cycle later alu_in_6B_1[3]=0x000011112222, alu_in_6B_2[3]=0x5, alu_in_valid=1 for 1 cycle; action_out equals the sent beat.
- 4B slot 2 op=0011, storeA=0x1A, imm=0xBEEF; 2B slot 0 op=1110, imm=0x1234 -> alu_in_4B_1[2]=0x1A, alu_in_4B_2[2]=0xBEEF, alu_in_4B_3[2]=cont4[2]; alu_in_2B_1[0]=0, alu_in_2B_2[0]=0x1234.
- All ops 0000 -> every A equals its own container, every B=0; phv_remain_data=phv_in[255:0].
- ready_in=0 while 3 back-to-back beats are offered -> 2 accepted; ready_out falls after the second; third held. ready_in=1 -> outputs B1, B2, B3 in order with no bubbles after the first.
- phv_in_valid=1 with action_in_valid=0 for 4 cycles -> alu_in_valid stays 0; action asserted -> exactly one beat out.
- N4=4, 4B slot 1 op=0001, idxA=6 -> operand A=0, idx_err_cnt=1; assert rst_n=0 mid-stall -> ready_out=1, alu_in_valid=0, idx_err_cnt=0 immediately.
